// File: rtl/idu_stage_pkg.sv
// Shared decode definitions for the IDU stage and the immediate extender:
// instruction-type codes, major opcodes and the ebreak encoding.
package idu_stage_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned TYPE_W = 3;
   localparam int unsigned REG_W  = 5;

   typedef enum logic [TYPE_W-1:0] {
      TYPE_R       = 3'd0,
      TYPE_I       = 3'd1,
      TYPE_S       = 3'd2,
      TYPE_B       = 3'd3,
      TYPE_U       = 3'd4,
      TYPE_J       = 3'd5,
      TYPE_INVALID = 3'd7
   } inst_type_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [INST_W-1:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/idu_classify.sv
// Combinational instruction classifier: opcode -> type code, RV32E register
// range check on the fields the format actually uses, and ebreak detect.
module idu_classify
   import idu_stage_pkg::*;
(
   input  logic [INST_W-1:0] inst_i,
   output inst_type_e        type_o,
   output logic              illegal_o,
   output logic              is_ebreak_o
);

   logic use_rd;
   logic use_rs1;
   logic use_rs2;

   always_comb begin
      type_o = TYPE_INVALID;
      case (inst_i[6:0])
         OPC_OP:                                    type_o = TYPE_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: type_o = TYPE_I;
         OPC_STORE:                                 type_o = TYPE_S;
         OPC_BRANCH:                                type_o = TYPE_B;
         OPC_LUI, OPC_AUIPC:                        type_o = TYPE_U;
         OPC_JAL:                                   type_o = TYPE_J;
         default:                                   type_o = TYPE_INVALID;
      endcase
   end

   // Which register fields the format reads/writes; unused field bits are free.
   always_comb begin
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (type_o)
         TYPE_R: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         TYPE_I: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
         end
         TYPE_S, TYPE_B: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         TYPE_U, TYPE_J: use_rd = 1'b1;
         default: ;
      endcase
   end

   assign illegal_o   = (type_o == TYPE_INVALID)
                      | (use_rd  & inst_i[11])
                      | (use_rs1 & inst_i[19])
                      | (use_rs2 & inst_i[24]);
   assign is_ebreak_o = (inst_i == EBREAK);

endmodule

// File: rtl/idu_stage.sv
// RV32E instruction-decode stage: single-entry valid/ready pipeline register
// for the fetched instruction, field slicing, classification and a beat counter.
module idu_stage
   import idu_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [REG_W-1:0]  rs1,
   output logic [REG_W-1:0]  rs2,
   output logic [REG_W-1:0]  rd,
   output logic [2:0]        funct3,
   output logic [6:0]        funct7,
   output logic [TYPE_W-1:0] type_o,
   output logic              illegal,
   output logic              is_ebreak,
   output logic [31:0]       dec_count
);

   localparam int unsigned CNT_W = 32;

   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q,  inst_d;
   logic [XLEN-1:0]   pc_q,    pc_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              accept;
   inst_type_e        type_s;

   // A redirect blocks the incoming beat so it is neither latched nor counted.
   assign in_ready = !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         inst_d  = in_inst;
         pc_d    = in_pc;
         cnt_d   = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   idu_classify u_classify (
      .inst_i      (inst_q),
      .type_o      (type_s),
      .illegal_o   (illegal),
      .is_ebreak_o (is_ebreak)
   );

   assign out_valid = valid_q;
   assign out_inst  = inst_q;
   assign out_pc    = pc_q;
   assign dec_count = cnt_q;
   assign type_o    = type_s;
   assign rs1       = inst_q[19:15];
   assign rs2       = inst_q[24:20];
   assign rd        = inst_q[11:7];
   assign funct3    = inst_q[14:12];
   assign funct7    = inst_q[31:25];

endmodule
